// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter producing the registered 2-bit decoder select.
// Ports: clk, rst_n (async low), req_in[3:0], release_in,
//        sel_out[1:0], grant_out[3:0], grant_valid_out, timeout_out.
module rr_sel_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_in,
    input  logic       release_in,
    output logic [1:0] sel_out,
    output logic [3:0] grant_out,
    output logic       grant_valid_out,
    output logic       timeout_out
);

    localparam int CW = $clog2(HOLD_MAX);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [1:0]    last_q;
    logic [1:0]    last_d;
    logic [CW-1:0] hold_q;
    logic [CW-1:0] hold_d;
    logic [1:0]    sel_d;
    logic [3:0]    grant_d;
    logic          valid_d;
    logic          to_d;
    logic [1:0]    winner;
    logic [1:0]    idx;
    logic          found;

    // Scan starts one past the last owner; i=4 wraps back to last itself.
    always_comb begin
        winner = 2'd0;
        idx    = 2'd0;
        found  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!found && req_in[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        sel_d   = sel_out;
        grant_d = grant_out;
        valid_d = grant_valid_out;
        to_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_in) begin
                    state_d = GRANT;
                    sel_d   = winner;
                    grant_d = 4'b0001 << winner;
                    valid_d = 1'b1;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                // Normal release outranks the hold limit.
                if (!req_in[sel_out] || release_in) begin
                    state_d = IDLE;
                    last_d  = sel_out;
                    grant_d = 4'b0000;
                    valid_d = 1'b0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = IDLE;
                    last_d  = sel_out;
                    grant_d = 4'b0000;
                    valid_d = 1'b0;
                    to_d    = 1'b1;
                end else begin
                    hold_d = hold_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            last_q          <= 2'd3;
            hold_q          <= '0;
            sel_out         <= 2'd0;
            grant_out       <= 4'b0000;
            grant_valid_out <= 1'b0;
            timeout_out     <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_q          <= last_d;
            hold_q          <= hold_d;
            sel_out         <= sel_d;
            grant_out       <= grant_d;
            grant_valid_out <= valid_d;
            timeout_out     <= to_d;
        end
    end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Self-checking bench for rr_sel_arbiter.
// Expected outputs are queued per driven cycle and compared after the edge.
module tb_rr_sel_arbiter;

    localparam int HM = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_in;
    logic       release_in;
    logic [1:0] sel_out;
    logic [3:0] grant_out;
    logic       grant_valid_out;
    logic       timeout_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       v;
        logic       to;
        string      name;
    } exp_t;

    exp_t q[$];

    rr_sel_arbiter #(.HOLD_MAX(HM)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_in          (req_in),
        .release_in      (release_in),
        .sel_out         (sel_out),
        .grant_out       (grant_out),
        .grant_valid_out (grant_valid_out),
        .timeout_out     (timeout_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, queue the expected post-edge outputs, compare.
    task automatic cyc(input logic [3:0] r, input logic rel,
                       input logic [1:0] es, input logic [3:0] eg,
                       input logic ev, input logic eto, input string nm);
        exp_t e;
        req_in     = r;
        release_in = rel;
        q.push_back('{sel: es, gnt: eg, v: ev, to: eto, name: nm});
        @(posedge clk);
        #1;
        e = q.pop_front();
        checks++;
        if ({sel_out, grant_out, grant_valid_out, timeout_out}
            !== {e.sel, e.gnt, e.v, e.to}) begin
            errors++;
            $display("FAIL %s: got sel=%0d gnt=%b v=%b to=%b, want sel=%0d gnt=%b v=%b to=%b",
                     e.name, sel_out, grant_out, grant_valid_out, timeout_out,
                     e.sel, e.gnt, e.v, e.to);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req_in     = 4'b1111;
        release_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({sel_out, grant_out, grant_valid_out, timeout_out} !== 8'b0) begin
            errors++;
            $display("FAIL reset_hold: got sel=%0d gnt=%b v=%b to=%b, want all 0",
                     sel_out, grant_out, grant_valid_out, timeout_out);
        end
        rst_n = 1'b1;
        cyc(4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, "reset_first_grant");
    endtask

    task automatic test_rotation();
        logic [1:0] o;
        cyc(4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, "rot_hold0");
        cyc(4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, "rot_rel0");
        for (int i = 1; i <= 4; i++) begin
            o = 2'(i);
            cyc(4'b1111, 1'b0, o, 4'b0001 << o, 1'b1, 1'b0, "rot_grant");
            cyc(4'b1111, 1'b0, o, 4'b0001 << o, 1'b1, 1'b0, "rot_hold");
            cyc(4'b1111, 1'b1, o, 4'b0000, 1'b0, 1'b0, "rot_rel");
        end
    endtask

    task automatic test_wrap_skip();
        cyc(4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, "wrap_own2");
        cyc(4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0, "wrap_rel2");
        cyc(4'b0011, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, "wrap_to0");
        cyc(4'b0011, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, "wrap_rel0");
        cyc(4'b0011, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0, "wrap_to1");
        cyc(4'b0011, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0, "wrap_rel1");
        cyc(4'b0011, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, "wrap_to0_again");
        cyc(4'b0011, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, "wrap_rel0_again");
    endtask

    task automatic test_timeout();
        cyc(4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, "to_grant");
        for (int i = 1; i < HM; i++)
            cyc(4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, "to_held");
        cyc(4'b0001, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, "to_forced");
        cyc(4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, "to_regrant");
    endtask

    task automatic test_coincident();
        for (int i = 1; i < HM; i++)
            cyc(4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, "co_held");
        cyc(4'b0001, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, "co_rel_at_limit");
        cyc(4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0, "drop_grant1");
        cyc(4'b1110, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0, "drop_other_bits");
        cyc(4'b1101, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0, "drop_owner");
    endtask

    task automatic test_async_reset();
        cyc(4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, "ar_grant2");
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sel_out, grant_out, grant_valid_out, timeout_out} !== 8'b0) begin
            errors++;
            $display("FAIL async_reset: got sel=%0d gnt=%b v=%b, want all 0",
                     sel_out, grant_out, grant_valid_out);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(4'b1100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, "ar_after_first");
    endtask

    initial begin
        rst_n      = 1'b0;
        req_in     = 4'b0000;
        release_in = 1'b0;
        test_reset();
        test_rotation();
        test_wrap_skip();
        test_timeout();
        test_coincident();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_sel_arbiter.md
# rr_sel_arbiter

Round-robin arbiter that converts four request lines into the registered 2-bit select consumed by the `priority_if` decoder stage (`sel_in`). The block grants one requester at a time, holds the grant until the owner releases or a hold limit expires, and presents the owner index on `sel_out`. It sits directly upstream of the decoder and replaces free-running stimulus on `sel_in` with a fair, clocked source.

## Interface
- `HOLD_MAX`, default 8. Maximum consecutive cycles one grant may be held; legal range 2..255.
- `clk`, input, 1. Single clock; all state updates on the rising edge.
- `rst_n`, input, 1. Reset, asynchronous and active-low.
- `req_in`, input, 4. Request per requester; bit i high means requester i wants the decoder.
- `release_in`, input, 1. Current owner is done; sampled only in GRANT.
- `sel_out`, output, 2. Registered owner index; drives decoder `sel_in`.
- `grant_out`, output, 4. Registered one-hot grant; all zero when no grant.
- `grant_valid_out`, output, 1. High while a grant is active (state GRANT).
- `timeout_out`, output, 1. One-cycle pulse when a grant is force-released by the hold limit.

## Operation
- Reset values: state IDLE, `sel_out`=0, `grant_out`=0, `grant_valid_out`=0, `timeout_out`=0, last-owner pointer=3, hold counter=0.
- States: IDLE, GRANT.
- IDLE: if `req_in`≠0, the winner is the first set bit scanning from (last+1) mod 4 upward, wrapping 3→0. Move to GRANT; load `sel_out`=winner, `grant_out`=1<<winner, hold counter=0. If `req_in`=0, stay in IDLE.
- GRANT, release conditions evaluated each edge, in priority order:
  - `req_in[sel_out]`=0 or `release_in`=1: normal release.
  - Hold counter = HOLD_MAX-1: forced release; `timeout_out`=1 for the following cycle.
  - Otherwise: hold counter increments and the grant is held.
- On any release: last-owner pointer=`sel_out`, `grant_out`=0, state becomes IDLE. Every grant is followed by at least one IDLE cycle.
- `sel_out` keeps its last value in IDLE, so the decoder input never glitches. `grant_valid_out`/`grant_out` qualify it.
- Changes to `req_in` bits other than the owner's have no effect during GRANT.
- Hold counter width is clog2(HOLD_MAX). It never wraps, because the forced release fires at HOLD_MAX-1.
- When normal release and timeout coincide on the same edge, the release is treated as normal and `timeout_out` stays 0.

## Timing
- Request-to-grant latency: 1 cycle. A request sampled at edge k in IDLE gives `grant_valid_out`=1 after edge k.
- Release latency: 1 cycle. The condition sampled at edge k clears `grant_valid_out` after edge k.
- Maximum grant length is HOLD_MAX cycles. The minimum re-grant gap is 1 IDLE cycle.
- Worst-case wait for a continuously requesting line is 3×(HOLD_MAX+1) cycles.
- `rst_n` asserted mid-grant clears all outputs immediately (asynchronously). The first grant after deassertion favours requester 0.

## Test plan
- Reset: hold `rst_n`=0 with `req_in`=4'b1111 → all outputs 0. After release at edge k: `sel_out`=0, `grant_out`=4'b0001 after edge k+1.
- Rotation: `req_in`=4'b1111, `release_in` pulsed on each second GRANT cycle → `sel_out` sequence 0,1,2,3,0 with one IDLE cycle between grants.
- Wrap and skip: last owner 2, `req_in`=4'b0011 → grant to 0, then grant to 1, then grant to 0 again.
- Timeout: HOLD_MAX=8, `req_in`=4'b0001 held, `release_in`=0 → `grant_valid_out` high exactly 8 cycles, `timeout_out` pulses once, 1 IDLE cycle, then requester 0 is granted again.
- Coincident events: `release_in`=1 on the edge where the hold counter = HOLD_MAX-1 → `timeout_out` stays 0. Owner's request drops mid-grant → release next cycle.
- Async reset mid-grant: `rst_n` low with `sel_out`=2 granted → `grant_out`=0, `sel_out`=0 before the next `clk` edge.
